// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared states, opcodes, op and ALUop codes for datapath_ctrl
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WR_IMM,
        S_GET_A,
        S_GET_B,
        S_ALU,
        S_WR_RES
    } state_t;

    typedef enum logic [2:0] {
        CLS_ILL,
        CLS_MOV_IMM,
        CLS_MOV_REG,
        CLS_ADD,
        CLS_CMP,
        CLS_AND,
        CLS_MVN
    } instr_cls_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

endpackage

// File: rtl/instr_dec.sv
// rtl/instr_dec.sv - combinational IR field slicer and instruction classifier
module instr_dec
    import ctrl_pkg::*;
(
    input  logic [15:0] ir,
    output logic [1:0]  op,
    output logic [2:0]  rn,
    output logic [2:0]  rd,
    output logic [1:0]  sh,
    output logic [2:0]  rm,
    output logic [15:0] imm_ext,
    output instr_cls_t  cls,
    output logic        illegal
);

    logic [2:0] opcode;

    assign opcode  = ir[15:13];
    assign op      = ir[12:11];
    assign rn      = ir[10:8];
    assign rd      = ir[7:5];
    assign sh      = ir[4:3];
    assign rm      = ir[2:0];
    assign imm_ext = {{8{ir[7]}}, ir[7:0]};
    assign illegal = (cls == CLS_ILL);

    // Map opcode/op pairs onto instruction classes; anything unlisted is illegal.
    always_comb begin
        cls = CLS_ILL;
        if (opcode == OPC_MOV) begin
            if (op == OP_MOV_IMM)      cls = CLS_MOV_IMM;
            else if (op == OP_MOV_REG) cls = CLS_MOV_REG;
        end else if (opcode == OPC_ALU) begin
            case (op)
                OP_ADD:  cls = CLS_ADD;
                OP_CMP:  cls = CLS_CMP;
                OP_AND:  cls = CLS_AND;
                default: cls = CLS_MVN;
            endcase
        end
    end

endmodule

// File: rtl/datapath_ctrl.sv
// rtl/datapath_ctrl.sv - instruction register and sequencer; DATAPATH_CTRL_ILLEGAL_TRAP_EN enables sticky err
module datapath_ctrl
    import ctrl_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [15:0]   ir_in,
    input  logic          load,
    input  logic          s,
    output logic          w,
    output logic          err,
    output logic [2:0]    writenum,
    output logic [2:0]    readnum,
    output logic          write,
    output logic          vsel,
    output logic          loada,
    output logic          loadb,
    output logic          loadc,
    output logic          loads,
    output logic          asel,
    output logic          bsel,
    output logic [1:0]    shift,
    output logic [1:0]    ALUop,
    output logic [DW-1:0] datapath_in
);

    state_t      state, state_nx;
    logic [15:0] ir_q;

    logic [1:0]  op;
    logic [2:0]  rn, rd, rm;
    logic [1:0]  sh;
    logic [15:0] imm_ext;
    instr_cls_t  cls;
    logic        illegal;

    instr_dec u_dec (
        .ir      (ir_q),
        .op      (op),
        .rn      (rn),
        .rd      (rd),
        .sh      (sh),
        .rm      (rm),
        .imm_ext (imm_ext),
        .cls     (cls),
        .illegal (illegal)
    );

    assign datapath_in = imm_ext;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_WAIT;
        else        state <= state_nx;
    end

    // IR only captures while idle, so it is stable for the whole instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        ir_q <= '0;
        else if (state == S_WAIT && load)  ir_q <= ir_in;
    end

`ifdef DATAPATH_CTRL_ILLEGAL_TRAP_EN
    logic err_q;

    // Sticky trap flag raised when DECODE sees an illegal word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          err_q <= 1'b0;
        else if (state == S_DECODE && illegal) err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Next-state and Moore control outputs from state plus IR.
    always_comb begin
        state_nx = state;
        w        = 1'b0;
        writenum = 3'd0;
        readnum  = 3'd0;
        write    = 1'b0;
        vsel     = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        shift    = 2'b00;
        ALUop    = 2'b00;
        case (state)
            S_WAIT: begin
                w = 1'b1;
                if (s) state_nx = S_DECODE;
            end
            S_DECODE: begin
                if (illegal) begin
                    state_nx = S_WAIT;
                end else begin
                    case (cls)
                        CLS_MOV_IMM:          state_nx = S_WR_IMM;
                        CLS_MOV_REG, CLS_MVN: state_nx = S_GET_B;
                        default:              state_nx = S_GET_A;
                    endcase
                end
            end
            S_WR_IMM: begin
                writenum = rn;
                vsel     = 1'b1;
                write    = 1'b1;
                state_nx = S_WAIT;
            end
            S_GET_A: begin
                readnum  = rn;
                loada    = 1'b1;
                state_nx = S_GET_B;
            end
            S_GET_B: begin
                readnum  = rm;
                loadb    = 1'b1;
                shift    = sh;
                state_nx = S_ALU;
            end
            S_ALU: begin
                shift = sh;
                ALUop = (cls == CLS_MOV_REG) ? ALU_ADD : op;
                asel  = (cls == CLS_MOV_REG) || (cls == CLS_MVN);
                if (cls == CLS_CMP) begin
                    loads    = 1'b1;
                    state_nx = S_WAIT;
                end else begin
                    loadc    = 1'b1;
                    state_nx = S_WR_RES;
                end
            end
            S_WR_RES: begin
                writenum = rd;
                write    = 1'b1;
                state_nx = S_WAIT;
            end
            default: state_nx = S_WAIT;
        endcase
    end

endmodule

// File: tb/tb_datapath_ctrl.sv
// tb/tb_datapath_ctrl.sv - directed self-checking bench for datapath_ctrl
module tb_datapath_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] ir_in;
    logic        load, s;
    logic        w, err;
    logic [2:0]  writenum, readnum;
    logic        write, vsel, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0]  shift, ALUop;
    logic [15:0] datapath_in;

    int n_chk  = 0;
    int n_fail = 0;
    logic exp_err;

    datapath_ctrl #(.DW(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ir_in       (ir_in),
        .load        (load),
        .s           (s),
        .w           (w),
        .err         (err),
        .writenum    (writenum),
        .readnum     (readnum),
        .write       (write),
        .vsel        (vsel),
        .loada       (loada),
        .loadb       (loadb),
        .loadc       (loadc),
        .loads       (loads),
        .asel        (asel),
        .bsel        (bsel),
        .shift       (shift),
        .ALUop       (ALUop),
        .datapath_in (datapath_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [15:0] word);
        ir_in = word;
        load  = 1'b1;
        s     = 1'b1;
        step();
        load  = 1'b0;
        s     = 1'b0;
    endtask

    initial begin
`ifdef DATAPATH_CTRL_ILLEGAL_TRAP_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        rst_n = 1'b1;
        ir_in = 16'h0000;
        load  = 1'b0;
        s     = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_w", {15'd0, w}, 16'd1);
        chk("rst_write", {15'd0, write}, 16'd0);
        chk("rst_err", {15'd0, err}, 16'd0);
        chk("rst_dpin", datapath_in, 16'h0000);
        step();
        rst_n = 1'b1;
        step();

        // MOV R0,#7
        start(16'hD007);
        chk("movi_dec_w", {15'd0, w}, 16'd0);
        chk("movi_dec_write", {15'd0, write}, 16'd0);
        step();
        chk("movi_write", {15'd0, write}, 16'd1);
        chk("movi_vsel", {15'd0, vsel}, 16'd1);
        chk("movi_wnum", {13'd0, writenum}, 16'd0);
        chk("movi_dpin", datapath_in, 16'h0007);
        chk("movi_w_low", {15'd0, w}, 16'd0);
        step();
        chk("movi_w_back", {15'd0, w}, 16'd1);

        // MOV R5,#-128
        start(16'hD580);
        step();
        chk("movn_dpin", datapath_in, 16'hFF80);
        chk("movn_wnum", {13'd0, writenum}, 16'd5);
        chk("movn_write", {15'd0, write}, 16'd1);
        step();
        chk("movn_w_back", {15'd0, w}, 16'd1);

        // ADD R2,R1,R0 LSL1; start/load during execution must be ignored
        start(16'hA148);
        chk("add_dec_loada", {15'd0, loada}, 16'd0);
        step();
        chk("add_geta_rnum", {13'd0, readnum}, 16'd1);
        chk("add_geta_loada", {15'd0, loada}, 16'd1);
        chk("add_geta_write", {15'd0, write}, 16'd0);
        ir_in = 16'hD0FF;
        load  = 1'b1;
        s     = 1'b1;
        step();
        load  = 1'b0;
        s     = 1'b0;
        chk("add_getb_rnum", {13'd0, readnum}, 16'd0);
        chk("add_getb_loadb", {15'd0, loadb}, 16'd1);
        chk("add_getb_shift", {14'd0, shift}, 16'd1);
        chk("add_getb_loada", {15'd0, loada}, 16'd0);
        step();
        chk("add_alu_op", {14'd0, ALUop}, 16'd0);
        chk("add_alu_loadc", {15'd0, loadc}, 16'd1);
        chk("add_alu_asel", {15'd0, asel}, 16'd0);
        chk("add_alu_loads", {15'd0, loads}, 16'd0);
        chk("add_alu_shift", {14'd0, shift}, 16'd1);
        chk("add_ir_stable", datapath_in, 16'h0048);
        step();
        chk("add_wr_wnum", {13'd0, writenum}, 16'd2);
        chk("add_wr_write", {15'd0, write}, 16'd1);
        chk("add_wr_vsel", {15'd0, vsel}, 16'd0);
        chk("add_wr_shift", {14'd0, shift}, 16'd0);
        chk("add_wr_w", {15'd0, w}, 16'd0);
        step();
        chk("add_w_back", {15'd0, w}, 16'd1);

        // CMP R1,R0
        start(16'hA900);
        step();
        chk("cmp_geta_rnum", {13'd0, readnum}, 16'd1);
        step();
        chk("cmp_getb_rnum", {13'd0, readnum}, 16'd0);
        step();
        chk("cmp_alu_loads", {15'd0, loads}, 16'd1);
        chk("cmp_alu_op", {14'd0, ALUop}, 16'd1);
        chk("cmp_alu_loadc", {15'd0, loadc}, 16'd0);
        chk("cmp_alu_write", {15'd0, write}, 16'd0);
        step();
        chk("cmp_w_back", {15'd0, w}, 16'd1);
        chk("cmp_no_write", {15'd0, write}, 16'd0);

        // MVN R3,R1
        start(16'hB861);
        step();
        chk("mvn_getb_loadb", {15'd0, loadb}, 16'd1);
        chk("mvn_getb_loada", {15'd0, loada}, 16'd0);
        chk("mvn_getb_rnum", {13'd0, readnum}, 16'd1);
        step();
        chk("mvn_alu_asel", {15'd0, asel}, 16'd1);
        chk("mvn_alu_op", {14'd0, ALUop}, 16'd3);
        chk("mvn_alu_loadc", {15'd0, loadc}, 16'd1);
        step();
        chk("mvn_wr_wnum", {13'd0, writenum}, 16'd3);
        chk("mvn_wr_write", {15'd0, write}, 16'd1);
        step();
        chk("mvn_w_back", {15'd0, w}, 16'd1);

        // Illegal 0x0000
        start(16'h0000);
        chk("ill_dec_write", {15'd0, write}, 16'd0);
        chk("ill_dec_w", {15'd0, w}, 16'd0);
        step();
        chk("ill_w_back", {15'd0, w}, 16'd1);
        chk("ill_err", {15'd0, err}, {15'd0, exp_err});
        step();
        chk("ill_err_sticky", {15'd0, err}, {15'd0, exp_err});

        // Asynchronous reset during GET_B of an ADD
        start(16'hA148);
        step();
        step();
        chk("rst_mid_loadb_pre", {15'd0, loadb}, 16'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_w", {15'd0, w}, 16'd1);
        chk("rst_mid_loadb", {15'd0, loadb}, 16'd0);
        chk("rst_mid_err", {15'd0, err}, 16'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("rst_after_write", {15'd0, write}, 16'd0);
        chk("rst_after_w", {15'd0, w}, 16'd1);
        step();
        chk("rst_after_write2", {15'd0, write}, 16'd0);
        chk("rst_after_dpin", datapath_in, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
